ha_array_reducer: RTL and testbench
===================================

# ha_array_reducer

Sequential consumer of the four half-adder row bundles produced by the 8x8 unsigned approximate partial-product stage. It accepts one bundle of rows per transaction over a valid/ready handshake and adds one weighted row per clock into a 17-bit accumulator. It then presents the 16-bit product over a second valid/ready handshake. It is the final-addition end of the row-array interface and replaces a wide single-cycle carry-propagate adder.

## Interface
- ROWS, 4, number of row bundles per transaction.
- T_W, 9, width of each row's `t` vector.
- B_W, 7, width of each row's `b` vector.
- ROW_SHIFT, 2, weight step between consecutive rows (bits).
- P_W, 16, product width.

- clk  in  1  single clock; all state updates on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  row bundle valid.
- in_ready  out  1  block can accept a bundle.
- row_t  in  ROWS*T_W  row k's `t` vector in bits [k*T_W +: T_W].
- row_b  in  ROWS*B_W  row k's `b` vector in bits [k*B_W +: B_W].
- out_valid  out  1  product valid.
- out_ready  in  1  downstream accepts the product.
- product  out  P_W  reduced product.
- ovf  out  1  accumulated sum exceeded 2^P_W-1. Only active with the configuration macro defined.

## Operation
- Row weighting:
  - `t[i]` of row k has weight 2^(ROW_SHIFT*k + i).
  - `b[i]` of row k has weight 2^(ROW_SHIFT*k + i + 2).
  - Row value R_k = ({t} + ({b} << 2)) << (ROW_SHIFT*k).
- Result: product = sum of R_0..R_{ROWS-1}.
  - The accumulator is P_W+1 bits wide and never wraps internally.
  - Maximum sum for the default parameters is 86615.
- States:
  - IDLE: in_ready=1, out_valid=0. When in_valid is high, the edge captures row_t and row_b into input registers, clears the accumulator and the row counter, and moves to ACC.
  - ACC: in_ready=0, out_valid=0. Each edge adds R_cnt to the accumulator and increments cnt. The edge with cnt==ROWS-1 adds the last row and moves to DONE.
  - DONE: out_valid=1 and product is held stable. When out_ready is high, the edge moves to IDLE.
- in_ready and out_valid are both driven from the registered state only. There is no combinational path from in_valid or out_ready to either signal.
- Input changes while not in IDLE are ignored; the registered copy of the rows is used.
- Reset, including mid-transaction:
  - State returns to IDLE; the in-flight bundle is discarded.
  - Reset values: in_ready=1, out_valid=0, product=0, ovf=0, and the accumulator, counter and input registers are all zero.

## Timing
- Bundle accepted at edge N → ROWS accumulate edges (N+1..N+ROWS) → out_valid is high in the cycle after edge N+ROWS.
- Default latency: 4 edges from acceptance to out_valid.
- Peak throughput: one transaction per ROWS+2 cycles, when out_ready is held high.
- out_valid may be held for any number of cycles; product and ovf are stable throughout.
- A new in_valid is first accepted in the cycle after the DONE→IDLE edge.

## Configuration
- HA_REDUCE_SAT_EN defined:
  - If accumulator bit P_W is set in DONE, product = all ones (16'hFFFF) and ovf = 1.
  - Otherwise ovf = 0.
- HA_REDUCE_SAT_EN undefined:
  - product = accumulator[P_W-1:0], i.e. modulo 2^P_W.
  - ovf is tied to 0.

## Test plan
- Reset, then all rows zero → out_valid after 4 edges with product=0, ovf=0; in_ready stays 0 during ACC/DONE.
- Row 0 t=9'h001, all other rows zero → product=16'h0001.
- Row 3 t=9'h1FF, b=7'h7F, other rows zero → product=16'hFEC0 (1019<<6), ovf=0.
- All rows t=9'h1FF, b=7'h7F → sum 86615:
  - With HA_REDUCE_SAT_EN: product=16'hFFFF, ovf=1.
  - Without it: product=16'h5257, ovf=0.
- out_ready held low for 10 cycles in DONE, with input bundles toggled meanwhile → product stable, no input accepted; raising out_ready returns to IDLE and the next bundle is accepted.
- rst_n asserted during ACC at cnt=2 → outputs go to their reset values immediately; after release, a fresh bundle completes correctly with no residue from the aborted one.

Source files
------------

// File: rtl/ha_array_reducer.sv
`default_nettype none
// ============================================================================
// Module   : ha_array_reducer
// Brief    : Row-serial final adder for the 8x8 approximate multiplier's four
//            half-adder row bundles; one weighted row accumulated per clock.
//            Optional saturation/overflow flag: define HA_REDUCE_SAT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module ha_array_reducer #(
    parameter int ROWS      = 4,
    parameter int T_W       = 9,
    parameter int B_W       = 7,
    parameter int ROW_SHIFT = 2,
    parameter int P_W       = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [ROWS*T_W-1:0] row_t,
    input  logic [ROWS*B_W-1:0] row_b,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [P_W-1:0]      product,
    output logic                ovf
);

    localparam int ACC_W = P_W + 1;
    localparam int CNT_W = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam logic [CNT_W-1:0] c_LAST = CNT_W'(ROWS - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACC  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                r_state;
    logic                  r_in_ready;
    logic                  r_out_valid;
    logic [ROWS*T_W-1:0]   r_t;
    logic [ROWS*B_W-1:0]   r_b;
    logic [CNT_W-1:0]      r_cnt;
    logic [ACC_W-1:0]      r_acc;
    logic [P_W-1:0]        r_product;

    logic [T_W-1:0]        w_t;
    logic [B_W-1:0]        w_b;
    logic [ACC_W-1:0]      w_base;
    logic [ACC_W-1:0]      w_row;
    logic [ACC_W-1:0]      w_sum;

    // Select the current row from the captured bundle and apply its weight.
    always_comb begin
        w_t    = '0;
        w_b    = '0;
        w_base = '0;
        w_row  = '0;
        for (int k = 0; k < ROWS; k++) begin
            if (r_cnt == CNT_W'(k)) begin
                w_t = r_t[k*T_W +: T_W];
                w_b = r_b[k*B_W +: B_W];
            end
        end
        w_base = {{(ACC_W-T_W){1'b0}}, w_t} + ({{(ACC_W-B_W){1'b0}}, w_b} << 2);
        for (int k = 0; k < ROWS; k++) begin
            if (r_cnt == CNT_W'(k)) begin
                w_row = w_base << (ROW_SHIFT * k);
            end
        end
    end

    assign w_sum = r_acc + w_row;

`ifdef HA_REDUCE_SAT_EN
    logic r_ovf;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_t         <= '0;
            r_b         <= '0;
            r_cnt       <= '0;
            r_acc       <= '0;
            r_product   <= '0;
`ifdef HA_REDUCE_SAT_EN
            r_ovf       <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_t        <= row_t;
                        r_b        <= row_b;
                        r_cnt      <= '0;
                        r_acc      <= '0;
                        r_in_ready <= 1'b0;
                        r_state    <= S_ACC;
                    end
                end
                S_ACC: begin
                    r_acc <= w_sum;
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == c_LAST) begin
                        // Result is latched here so it stays fixed for the whole of DONE.
`ifdef HA_REDUCE_SAT_EN
                        r_product <= w_sum[P_W] ? {P_W{1'b1}} : w_sum[P_W-1:0];
                        r_ovf     <= w_sum[P_W];
`else
                        r_product <= w_sum[P_W-1:0];
`endif
                        r_out_valid <= 1'b1;
                        r_state     <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign product   = r_product;
`ifdef HA_REDUCE_SAT_EN
    assign ovf = r_ovf;
`else
    assign ovf = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ha_array_reducer.sv
`default_nettype none
// ============================================================================
// Module   : tb_ha_array_reducer
// Brief    : Directed self-checking bench for ha_array_reducer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ha_array_reducer;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [35:0] row_t;
    logic [27:0] row_b;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] product;
    logic        ovf;

    int total = 0;
    int bad   = 0;

    ha_array_reducer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .row_t     (row_t),
        .row_b     (row_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .product   (product),
        .ovf       (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present a bundle, confirm 4-edge latency and the result, hold DONE for
    // 'hold' extra cycles with inputs toggling, then release it.
    task automatic run(input string tag, input logic [35:0] t, input logic [27:0] b,
                       input logic [15:0] ep, input logic eo, input int hold);
        int n;
        logic rdy_ok;
        @(negedge clk);
        chk({tag, "_in_ready_idle"}, {31'd0, in_ready}, 32'd1);
        row_t    = t;
        row_b    = b;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        row_t    = ~t;
        row_b    = ~b;
        n        = 0;
        rdy_ok   = 1'b1;
        while (out_valid !== 1'b1 && n < 20) begin
            if (in_ready !== 1'b0) rdy_ok = 1'b0;
            @(negedge clk);
            n++;
        end
        chk({tag, "_latency"}, n, 32'd4);
        chk({tag, "_in_ready_acc"}, {31'd0, rdy_ok}, 32'd1);
        chk({tag, "_product"}, {16'd0, product}, {16'd0, ep});
        chk({tag, "_ovf"}, {31'd0, ovf}, {31'd0, eo});
        rdy_ok = 1'b1;
        for (int i = 0; i < hold; i++) begin
            in_valid = ~in_valid;
            row_t    = {$urandom, 4'h5};
            row_b    = 28'($urandom);
            @(negedge clk);
            if (product !== ep || out_valid !== 1'b1 || in_ready !== 1'b0) rdy_ok = 1'b0;
        end
        if (hold > 0) chk({tag, "_held_stable"}, {31'd0, rdy_ok}, 32'd1);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({tag, "_out_valid_released"}, {31'd0, out_valid}, 32'd0);
        chk({tag, "_in_ready_back"}, {31'd0, in_ready}, 32'd1);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        row_t     = '0;
        row_b     = '0;
        repeat (2) @(negedge clk);
        chk("rst_in_ready",  {31'd0, in_ready},  32'd1);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_product",   {16'd0, product},   32'd0);
        chk("rst_ovf",       {31'd0, ovf},       32'd0);
        rst_n = 1'b1;

        run("zero",    36'h0,         28'h0,       16'h0000, 1'b0, 0);
        run("row0_t1", 36'h1,         28'h0,       16'h0001, 1'b0, 0);
        run("row3_max",36'hFF8000000, 28'hFE00000, 16'hFEC0, 1'b0, 0);
`ifdef HA_REDUCE_SAT_EN
        run("all_max", 36'hFFFFFFFFF, 28'hFFFFFFF, 16'hFFFF, 1'b1, 0);
`else
        run("all_max", 36'hFFFFFFFFF, 28'hFFFFFFF, 16'h5257, 1'b0, 0);
`endif
        run("mixed",   36'h0AA,       28'h280,     16'h00FA, 1'b0, 0);
        run("stall",   36'hA00,       28'h0,       16'h0014, 1'b0, 10);
        run("after_stall", 36'h000C0000, 28'h80,   16'h0040, 1'b0, 0);

        // Abort a transaction while cnt==2.
        @(negedge clk);
        row_t    = 36'hFFFFFFFFF;
        row_b    = 28'hFFFFFFF;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_in_ready",  {31'd0, in_ready},  32'd1);
        chk("abort_out_valid", {31'd0, out_valid}, 32'd0);
        chk("abort_product",   {16'd0, product},   32'd0);
        chk("abort_ovf",       {31'd0, ovf},       32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run("post_abort", 36'h1, 28'h1, 16'h0005, 1'b0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
